// File: rtl/mips16_pkg.sv
// Shared types and sizes for the mips16 fetch path.
package mips16_pkg;

  localparam int WORD_W   = 16;
  localparam int TAG_W    = WORD_W - 1;  // halfword address, bit 0 dropped
  localparam int PF_DEPTH = 4;

  // IDLE  : no memory read outstanding
  // REQ   : read outstanding, its data will be queued
  // DRAIN : read outstanding, its data will be thrown away (stale after redirect)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } pf_state_e;

endpackage

// File: rtl/pf_fifo.sv
// Tagged prefetch queue: each entry pairs a fetched word with its halfword address.
module pf_fifo
  import mips16_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [CW-1:0]     count,
  output logic [TAG_W-1:0]  head_tag,
  output logic [WORD_W-1:0] head_data
);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [WORD_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      tag_mem[wr_ptr]  <= push_tag;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: keeps a small queue of sequential instruction words
// ahead of the datapath PC and restarts fetching whenever the PC jumps.
//
// Memory handshake: imem_req is held high while one read is outstanding and
// imem_addr stays constant for that whole time. The memory completes the read
// by pulsing imem_ack for one cycle with imem_rdata valid in that same cycle.
// A new read may start in the cycle right after the ack (or in the ack cycle's
// next-state when the FSM stays in REQ). Never more than one read is in flight.
module instr_prefetch
  import mips16_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  input  logic              advance,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output pf_state_e         dbg_state,
  output logic [CW-1:0]     dbg_count
);

  pf_state_e         state;
  pf_state_e         state_n;
  logic [WORD_W-1:0] fa;          // next address to fetch
  logic [WORD_W-1:0] fa_n;
  logic [WORD_W-1:0] addr_n;
  logic [WORD_W-1:0] addr_plus2;
  logic [CW-1:0]     count;
  logic [TAG_W-1:0]  head_tag;
  logic [WORD_W-1:0] head_data;
  logic [TAG_W-1:0]  exp_tag;
  logic [CW-1:0]     occ_after;
  logic              has_room;
  logic              room_after_push;
  logic              push;
  logic              pop;
  logic              redirect;
  logic              unused_pc0;

  // Instruction bit 0 of the PC never selects anything.
  assign unused_pc0 = pc[0];

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_tag  (imem_addr[WORD_W-1:1]),
    .push_data (imem_rdata),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head_tag  (head_tag),
    .head_data (head_data)
  );

  // Datapath-facing view of the queue head.
  always_comb begin
    instr_valid = (count != '0) && (head_tag == pc[WORD_W-1:1]);
    instr       = (count != '0) ? head_data : '0;
    stall       = ~instr_valid;
    pop         = advance & instr_valid;
  end

  // Redirect detection: compare the PC against the address we expect it to be.
  always_comb begin
    if (count != '0)
      exp_tag = head_tag;
    else if (state == REQ)
      exp_tag = imem_addr[WORD_W-1:1];
    else
      exp_tag = fa[WORD_W-1:1];
    redirect = (exp_tag != pc[WORD_W-1:1]);
  end

  // Room checks account for this cycle's pop (and the push when it lands).
  always_comb begin
    occ_after       = count - CW'(pop);
    has_room        = ({1'b0, occ_after} < (CW+1)'(DEPTH));
    room_after_push = (({1'b0, occ_after} + (CW+1)'(1)) < (CW+1)'(DEPTH));
    addr_plus2      = imem_addr + WORD_W'(2);
  end

  // Fetch FSM next-state, next-fetch address and read address.
  always_comb begin
    state_n = state;
    fa_n    = fa;
    addr_n  = imem_addr;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fa_n = {pc[WORD_W-1:1], 1'b0};
        end else if (has_room) begin
          state_n = REQ;
          addr_n  = fa;
        end
      end
      REQ: begin
        if (redirect) begin
          fa_n    = {pc[WORD_W-1:1], 1'b0};
          // a read completing now is simply dropped; otherwise wait it out
          state_n = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          push = 1'b1;
          fa_n = addr_plus2;
          if (room_after_push)
            addr_n = addr_plus2;
          else
            state_n = IDLE;
        end
      end
      DRAIN: begin
        if (redirect)
          fa_n = {pc[WORD_W-1:1], 1'b0};
        // the stale read has finished; its data is discarded
        if (imem_ack)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, next-fetch and read-address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fa        <= '0;
      imem_addr <= '0;
    end else begin
      state     <= state_n;
      fa        <= fa_n;
      imem_addr <= addr_n;
    end
  end

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign dbg_state = state;
  assign dbg_count = count;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: a memory responder with configurable wait states,
// a datapath model that steps the PC on consumed instructions, and scenario tasks.
module tb_instr_prefetch;
  import mips16_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic        advance;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  pf_state_e   dbg_state;
  logic [2:0]  dbg_count;

  int          checks;
  int          errors;
  int          mem_wait;      // fixed wait cycles, or -1 for random 0..3 per read
  logic [15:0] mem_salt;
  logic [15:0] ack_log[$];    // addresses whose reads the memory completed
  logic [15:0] exp_q[$];

  instr_prefetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .advance     (advance),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dbg_state   (dbg_state),
    .dbg_count   (dbg_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL time_limit sim time %0t exceeded, got no finish, need finish", $time);
    $fatal(1, "time limit");
  end

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ mem_salt;
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    int          req_cycles;
    int          cur_wait;
    logic [15:0] cur_addr;
    req_cycles = 0;
    cur_wait   = 0;
    cur_addr   = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || !imem_req) begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        req_cycles = 0;
      end else begin
        if (req_cycles == 0) begin
          cur_addr = imem_addr;
          cur_wait = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
        end else begin
          checks++;
          if (imem_addr !== cur_addr) begin
            errors++;
            $display("FAIL addr_stable got=%h exp=%h", imem_addr, cur_addr);
          end
        end
        checks++;
        if (imem_addr[0] !== 1'b0) begin
          errors++;
          $display("FAIL addr_bit0 got=%h exp bit0=0", imem_addr);
        end
        if (req_cycles >= cur_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          ack_log.push_back(imem_addr);
          req_cycles = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'hDEAD;
          req_cycles++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [15:0] start_pc);
    reset   = 1'b1;
    advance = 1'b0;
    pc      = start_pc;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_log.delete();
    #1;
  endtask

  // One datapath cycle, entered and left just after a falling edge.
  task automatic dp_cycle(input logic adv, output logic v);
    logic fire;
    advance = adv;
    v = instr_valid;
    checks++;
    if (stall !== ~instr_valid) begin
      errors++;
      $display("FAIL stall_inv stall=%b exp=%b", stall, ~instr_valid);
    end
    if (instr_valid === 1'b1) begin
      checks++;
      if (instr !== mem_word(pc)) begin
        errors++;
        $display("FAIL instr_data pc=%h got=%h exp=%h", pc, instr, mem_word(pc));
      end
    end
    if (dbg_count === 3'd0) begin
      checks++;
      if (instr !== 16'h0000) begin
        errors++;
        $display("FAIL instr_empty got=%h exp=0000", instr);
      end
    end
    fire = adv & instr_valid;
    @(posedge clk);
    #1;
    if (fire) pc = pc + 16'd2;
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset   = 1'b1;
    advance = 1'b0;
    pc      = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (stall !== 1'b1)       begin errors++; $display("FAIL rst_stall got=%b exp=1", stall); end
    checks++; if (instr !== 16'h0000)   begin errors++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    checks++; if (imem_addr !== 16'h0)  begin errors++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
    checks++; if (dbg_state !== IDLE)   begin errors++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++; if (dbg_count !== 3'd0)   begin errors++; $display("FAIL rst_count got=%0d exp=0", dbg_count); end
  endtask

  task automatic test_zero_wait;
    logic v;
    logic exp_v;
    mem_wait = 0;
    do_reset(16'h0000);
    for (int k = 0; k < 22; k++) begin
      exp_v = (k >= 2);
      checks++;
      if (instr_valid !== exp_v) begin
        errors++;
        $display("FAIL zw_valid cycle=%0d got=%b exp=%b", k, instr_valid, exp_v);
      end
      if (k == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
          errors++;
          $display("FAIL zw_first_req req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
        end
      end
      dp_cycle(1'b1, v);
    end
    checks++;
    if (pc !== 16'd40) begin errors++; $display("FAIL zw_pc got=%h exp=0028", pc); end
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(16'(2 * i));
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      logic [15:0] g;
      e = exp_q.pop_front();
      g = (ack_log.size() > 0) ? ack_log.pop_front() : 16'hBEEF;
      checks++;
      if (g !== e) begin errors++; $display("FAIL zw_fetch_seq got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_wait_states;
    logic v;
    logic exp_v;
    mem_wait = 3;
    do_reset(16'h0000);
    for (int k = 0; k < 29; k++) begin
      exp_v = (k >= 5) && (((k - 5) % 4) == 0);
      checks++;
      if (instr_valid !== exp_v) begin
        errors++;
        $display("FAIL ws_valid cycle=%0d got=%b exp=%b", k, instr_valid, exp_v);
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL ws_req cycle=%0d got=%b exp=1", k, imem_req); end
      end
      dp_cycle(1'b1, v);
    end
    checks++;
    if (pc !== 16'd12) begin errors++; $display("FAIL ws_pc got=%h exp=000c", pc); end
  endtask

  task automatic test_fill;
    logic v;
    mem_wait = int'($urandom_range(0, 2));
    do_reset(16'h0000);
    repeat (20) dp_cycle(1'b0, v);
    checks++; if (dbg_count !== 3'd4)  begin errors++; $display("FAIL fill_count got=%0d exp=4", dbg_count); end
    checks++; if (dbg_state !== IDLE)  begin errors++; $display("FAIL fill_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++;
    if (ack_log.size() != 4) begin
      errors++;
      $display("FAIL fill_nreads got=%0d exp=4", ack_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_log[i] !== 16'(2 * i)) begin
          errors++;
          $display("FAIL fill_addr idx=%0d got=%h exp=%h", i, ack_log[i], 16'(2 * i));
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== mem_word(16'h0000)) begin
        errors++;
        $display("FAIL fill_hold req=%b valid=%b instr=%h exp req=0 valid=1 instr=%h",
                 imem_req, instr_valid, instr, mem_word(16'h0000));
      end
      dp_cycle(1'b0, v);
    end
    repeat (12) dp_cycle(1'b1, v);
    checks++;
    if (pc < 16'd8) begin errors++; $display("FAIL fill_drain pc=%h exp>=0008", pc); end
  endtask

  task automatic test_redirect_flush;
    logic v;
    mem_wait = int'($urandom_range(0, 2));
    do_reset(16'h0010);
    for (int k = 0; k < 40 && dbg_count !== 3'd4; k++) dp_cycle(1'b0, v);
    checks++;
    if (dbg_count !== 3'd4) begin errors++; $display("FAIL rf_fill count=%0d exp=4", dbg_count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack_log.size() <= i || ack_log[i] !== 16'h0010 + 16'(2 * i)) begin
        errors++;
        $display("FAIL rf_queued idx=%0d got=%h exp=%h", i,
                 (ack_log.size() > i) ? ack_log[i] : 16'hBEEF, 16'h0010 + 16'(2 * i));
      end
    end
    ack_log.delete();
    pc = 16'h0100;
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_stale_valid got=%b exp=0", instr_valid); end
    dp_cycle(1'b0, v);
    checks++; if (dbg_count !== 3'd0)  begin errors++; $display("FAIL rf_flush count=%0d exp=0", dbg_count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_post_valid got=%b exp=0", instr_valid); end
    for (int k = 0; k < 20 && pc !== 16'h0102; k++) dp_cycle(1'b1, v);
    checks++;
    if (pc !== 16'h0102) begin errors++; $display("FAIL rf_progress pc=%h exp=0102", pc); end
    checks++;
    if (ack_log.size() == 0 || ack_log[0] !== 16'h0100) begin
      errors++;
      $display("FAIL rf_next_fetch got=%h exp=0100", (ack_log.size() > 0) ? ack_log[0] : 16'hBEEF);
    end
  endtask

  task automatic test_drain;
    logic v;
    logic seen;
    mem_wait = 6;
    do_reset(16'h0008);
    for (int k = 0; k < 10 && !(imem_req === 1'b1 && imem_addr === 16'h0008); k++) dp_cycle(1'b0, v);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL dr_req req=%b addr=%h exp req=1 addr=0008", imem_req, imem_addr);
    end
    pc = 16'h0040;
    dp_cycle(1'b0, v);
    checks++;
    if (dbg_state !== DRAIN || imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL dr_enter state=%0d req=%b addr=%h exp state=%0d req=1 addr=0008",
               dbg_state, imem_req, imem_addr, DRAIN);
    end
    for (int k = 0; k < 10 && ack_log.size() < 1; k++) dp_cycle(1'b0, v);
    checks++;
    if (ack_log.size() < 1 || ack_log[0] !== 16'h0008) begin
      errors++;
      $display("FAIL dr_ack got=%h exp=0008", (ack_log.size() > 0) ? ack_log[0] : 16'hBEEF);
    end
    dp_cycle(1'b0, v);
    checks++;
    if (dbg_state !== IDLE || dbg_count !== 3'd0) begin
      errors++;
      $display("FAIL dr_dropped state=%0d count=%0d exp state=%0d count=0", dbg_state, dbg_count, IDLE);
    end
    for (int k = 0; k < 20 && ack_log.size() < 2; k++) dp_cycle(1'b0, v);
    checks++;
    if (ack_log.size() < 2 || ack_log[1] !== 16'h0040) begin
      errors++;
      $display("FAIL dr_next_fetch got=%h exp=0040", (ack_log.size() > 1) ? ack_log[1] : 16'hBEEF);
    end
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) dp_cycle(1'b0, seen);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL dr_valid got=%b exp=1", seen); end
  endtask

  task automatic test_wrap;
    logic v;
    mem_wait = 0;
    do_reset(16'hFFFE);
    repeat (8) dp_cycle(1'b1, v);
    checks++;
    if (ack_log.size() < 2 || ack_log[0] !== 16'hFFFE || ack_log[1] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_fetch got=%h,%h exp=fffe,0000",
               (ack_log.size() > 0) ? ack_log[0] : 16'hBEEF, (ack_log.size() > 1) ? ack_log[1] : 16'hBEEF);
    end
    checks++;
    if (pc !== 16'h0008) begin errors++; $display("FAIL wrap_pc got=%h exp=0008", pc); end
  endtask

  task automatic test_reset_mid_req;
    logic v;
    mem_wait = 5;
    do_reset(16'h0020);
    for (int k = 0; k < 6 && imem_req !== 1'b1; k++) dp_cycle(1'b1, v);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL rm_req req=%b addr=%h exp req=1 addr=0020", imem_req, imem_addr);
    end
    #2;
    reset = 1'b1;
    pc    = 16'h0000;
    #1;
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL rm_async_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 16'h0) begin errors++; $display("FAIL rm_async_addr got=%h exp=0000", imem_addr); end
    checks++; if (dbg_state !== IDLE)  begin errors++; $display("FAIL rm_async_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++; if (stall !== 1'b1)      begin errors++; $display("FAIL rm_async_stall got=%b exp=1", stall); end
    @(negedge clk);
    reset = 1'b0;
    ack_log.delete();
    #1;
    for (int k = 0; k < 20 && pc !== 16'h0002; k++) dp_cycle(1'b1, v);
    checks++;
    if (pc !== 16'h0002) begin errors++; $display("FAIL rm_progress pc=%h exp=0002", pc); end
    checks++;
    if (ack_log.size() == 0 || ack_log[0] !== 16'h0000) begin
      errors++;
      $display("FAIL rm_first_fetch got=%h exp=0000", (ack_log.size() > 0) ? ack_log[0] : 16'hBEEF);
    end
  endtask

  task automatic test_random;
    logic        v;
    logic [15:0] tmp;
    int          gap;
    int          max_gap;
    int          consumed;
    mem_wait = -1;
    tmp = 16'($urandom_range(0, 65535));
    do_reset({tmp[15:1], 1'b0});
    gap      = 0;
    max_gap  = 0;
    consumed = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        tmp = 16'($urandom_range(0, 65535));
        pc  = {tmp[15:1], 1'b0};
        gap = 0;
        #1;
      end
      dp_cycle(($urandom_range(0, 3) != 0), v);
      if (v) begin
        consumed++;
        gap = 0;
      end else begin
        gap++;
      end
      if (gap > max_gap) max_gap = gap;
    end
    checks++;
    if (max_gap > 30) begin errors++; $display("FAIL rnd_gap got=%0d exp<=30", max_gap); end
    checks++;
    if (consumed < 100) begin errors++; $display("FAIL rnd_throughput got=%0d exp>=100", consumed); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    mem_wait = 0;
    mem_salt = 16'($urandom_range(0, 65535));
    reset    = 1'b1;
    advance  = 1'b0;
    pc       = 16'h0000;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_fill();
    test_redirect_flush();
    test_drain();
    test_wrap();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
